display_receiver: RTL and testbench

Receive-side model of the LED panel serial interface. It sits on the far end of the `rgb`/`oclk`/`lat`/`oe`/`row` bus and rebuilds what the panel would show: it deserialises shifted pixels, captures them on latch, streams the latched row out, and measures how long each latched row was lit. It is used as a self-checking sink in display-controller benches and as the input stage for chained-panel experiments. All bus inputs come from the same `clk` domain as the driver.

---
 rtl/display_receiver.sv | 145 ++++++++++++++
 tb/tb_display_receiver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_receiver.sv
// display_receiver: LED panel bus sink that rebuilds latched rows, streams them out and measures lit time
module display_receiver #(
  parameter int segments = 1,
  parameter int rows = 8,
  parameter int columns = 32,
  parameter int cntwidth = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(rows)-1:0]      row,
  input  logic [segments*3-1:0]        rgb,
  input  logic                         oclk,
  input  logic                         lat,
  input  logic                         oe,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic [$clog2(rows)-1:0]      px_row,
  output logic [$clog2(columns)-1:0]   px_column,
  output logic [segments*3-1:0]        px_rgb,
  output logic                         px_last,
  output logic                         on_valid,
  output logic [$clog2(rows)-1:0]      on_row,
  output logic [cntwidth-1:0]          on_cycles,
  output logic                         err_length,
  output logic                         err_latch_oe,
  output logic                         err_overrun
);
  localparam int rw = $clog2(rows);
  localparam int cw = $clog2(columns);
  localparam int sw = $clog2(columns + 1);
  localparam int dw = segments * 3;
  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_stream = 1'b1;
  logic [rw-1:0] s_row_q, latched_row_q, latched_row_d, on_row_q, on_row_d;
  logic [dw-1:0] s_rgb_q;
  logic s_oclk_q, s_lat_q, s_oe_q, p_oclk_q, p_lat_q, p_oe_q;
  logic [dw-1:0] shift_buf_q [columns];
  logic [dw-1:0] shift_buf_d [columns];
  logic [dw-1:0] latch_buf_q [columns];
  logic [dw-1:0] latch_buf_d [columns];
  logic [sw-1:0] shift_count_q, shift_count_d;
  logic [cw-1:0] column_q, column_d;
  logic [0:0] state_q, state_d;
  logic [cntwidth-1:0] on_count_q, on_count_d, on_cycles_q, on_cycles_d;
  logic on_valid_q, on_valid_d;
  logic err_length_q, err_length_d, err_latch_oe_q, err_latch_oe_d, err_overrun_q, err_overrun_d;
  logic oclk_rise, lat_rise, oe_fall, busy, accept, last;

  always_comb begin
    oclk_rise = s_oclk_q & ~p_oclk_q;
    lat_rise = s_lat_q & ~p_lat_q;
    oe_fall = ~s_oe_q & p_oe_q;
    busy = state_q == st_stream;
    last = column_q == cw'(columns - 1);
    accept = busy & px_ready;
    shift_buf_d = shift_buf_q;
    shift_count_d = shift_count_q;
    if (oclk_rise && shift_count_q != sw'(columns)) begin
      shift_buf_d[shift_count_q[cw-1:0]] = s_rgb_q;
      shift_count_d = shift_count_q + 1'b1;
    end
    state_d = (accept && last) ? st_idle : state_q;
    column_d = accept ? (last ? '0 : column_q + 1'b1) : column_q;
    latch_buf_d = latch_buf_q;
    latched_row_d = latched_row_q;
    on_count_d = oe_fall ? '0 : (s_oe_q && on_count_q != '1) ? on_count_q + 1'b1 : on_count_q;
    on_valid_d = oe_fall;
    on_row_d = oe_fall ? latched_row_q : on_row_q;
    on_cycles_d = oe_fall ? on_count_q : on_cycles_q;
    err_length_d = err_length_q | (lat_rise && shift_count_q != sw'(columns));
    err_latch_oe_d = err_latch_oe_q | (lat_rise & s_oe_q);
    err_overrun_d = err_overrun_q | (lat_rise & busy);
    // a latch that lands on a busy stream is dropped but still restarts shift and on-time counting
    if (lat_rise) begin
      shift_count_d = '0;
      on_count_d = '0;
      if (!busy) begin
        latch_buf_d = shift_buf_q;
        latched_row_d = s_row_q;
        state_d = st_stream;
        column_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_row_q <= '0;
      s_rgb_q <= '0;
      s_oclk_q <= 1'b0;
      s_lat_q <= 1'b0;
      s_oe_q <= 1'b0;
      p_oclk_q <= 1'b0;
      p_lat_q <= 1'b0;
      p_oe_q <= 1'b0;
      shift_buf_q <= '{default: '0};
      latch_buf_q <= '{default: '0};
      shift_count_q <= '0;
      column_q <= '0;
      state_q <= st_idle;
      latched_row_q <= '0;
      on_count_q <= '0;
      on_cycles_q <= '0;
      on_row_q <= '0;
      on_valid_q <= 1'b0;
      err_length_q <= 1'b0;
      err_latch_oe_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      s_row_q <= row;
      s_rgb_q <= rgb;
      s_oclk_q <= oclk;
      s_lat_q <= lat;
      s_oe_q <= oe;
      p_oclk_q <= s_oclk_q;
      p_lat_q <= s_lat_q;
      p_oe_q <= s_oe_q;
      shift_buf_q <= shift_buf_d;
      latch_buf_q <= latch_buf_d;
      shift_count_q <= shift_count_d;
      column_q <= column_d;
      state_q <= state_d;
      latched_row_q <= latched_row_d;
      on_count_q <= on_count_d;
      on_cycles_q <= on_cycles_d;
      on_row_q <= on_row_d;
      on_valid_q <= on_valid_d;
      err_length_q <= err_length_d;
      err_latch_oe_q <= err_latch_oe_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign px_valid = state_q == st_stream;
  assign px_row = latched_row_q;
  assign px_column = column_q;
  assign px_rgb = latch_buf_q[column_q];
  assign px_last = px_valid & last;
  assign on_valid = on_valid_q;
  assign on_row = on_row_q;
  assign on_cycles = on_cycles_q;
  assign err_length = err_length_q;
  assign err_latch_oe = err_latch_oe_q;
  assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_display_receiver.sv
// tb_display_receiver: drives the panel bus and checks the rebuilt rows and on-time reports against a transaction model
module tb_display_receiver;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] row = '0, rgb = '0;
  logic oclk = 1'b0, lat = 1'b0, oe = 1'b0, px_ready = 1'b1;
  logic px_valid, px_last, on_valid, err_length, err_latch_oe, err_overrun;
  logic [2:0] px_row, px_rgb, on_row;
  logic [4:0] px_column;
  logic [15:0] on_cycles;
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [2:0] row; logic [4:0] col; logic [2:0] rgb; logic last;} px_t;
  typedef struct {logic [2:0] row; logic [15:0] cyc;} on_t;
  px_t exp_px[$];
  on_t exp_on[$];
  logic [2:0] m_buf[32];
  int m_cnt, m_on;
  logic [2:0] m_row;
  logic m_err_len, m_err_oe, m_err_ovr, p_oclk, p_lat, p_oe;

  display_receiver dut (
    .clk(clk), .rst(rst), .row(row), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe),
    .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row), .px_column(px_column),
    .px_rgb(px_rgb), .px_last(px_last), .on_valid(on_valid), .on_row(on_row),
    .on_cycles(on_cycles), .err_length(err_length), .err_latch_oe(err_latch_oe),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_buf[i]) m_buf[i] = '0;
    m_cnt = 0; m_on = 0; m_row = '0;
    m_err_len = 0; m_err_oe = 0; m_err_ovr = 0;
    p_oclk = 0; p_lat = 0; p_oe = 0;
    exp_px.delete();
    exp_on.delete();
  endfunction

  // one input cycle of the bus as the panel sees it: rows are whole transactions, on-time is a counted interval
  function automatic void model_step();
    px_t e;
    on_t o;
    if (oclk && !p_oclk && m_cnt < 32) begin
      m_buf[m_cnt] = rgb;
      m_cnt++;
    end
    if (!oe && p_oe) begin
      o.row = m_row; o.cyc = 16'(m_on);
      exp_on.push_back(o);
      m_on = 0;
    end
    if (lat && !p_lat) begin
      if (m_cnt != 32) m_err_len = 1;
      if (oe) m_err_oe = 1;
      if (exp_px.size() != 0) m_err_ovr = 1;
      else begin
        m_row = row;
        for (int c = 0; c < 32; c++) begin
          e.row = row; e.col = c[4:0]; e.rgb = m_buf[c]; e.last = (c == 31);
          exp_px.push_back(e);
        end
      end
      m_cnt = 0; m_on = 0;
    end else if (oe && m_on < 65535) m_on++;
    p_oclk = oclk; p_lat = lat; p_oe = oe;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [2:0] v);
    rgb = v; oclk = 1'b1; tick();
    oclk = 1'b0; tick();
  endtask

  task automatic latch(input logic [2:0] r);
    row = r; lat = 1'b1; tick();
    lat = 1'b0; tick();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && (px_valid || exp_px.size() != 0); i++) tick();
    chk({name, " stream drained"}, {63'd0, px_valid}, 64'd0);
  endtask

  task automatic flags(input string name, input logic [2:0] e);
    chk({name, " dut flags"}, {61'd0, err_length, err_latch_oe, err_overrun}, {61'd0, e});
    chk({name, " model flags"}, {61'd0, m_err_len, m_err_oe, m_err_ovr}, {61'd0, e});
  endtask

  task automatic watch_col(input string name, input logic [2:0] e);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (px_valid && px_column == 5'd31) begin
        seen = 1;
        chk(name, {61'd0, px_rgb}, {61'd0, e});
      end else tick();
    end
    if (!seen) chk({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic all_zero(input string name);
    chk(name, {px_valid, px_row, px_column, px_rgb, px_last, on_valid, on_row, on_cycles,
               err_length, err_latch_oe, err_overrun}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (px_valid) begin
        if (exp_px.size() == 0) chk("px unexpected beat", {59'd0, px_column}, 64'hffff);
        else begin
          chk("px beat", {px_row, px_column, px_rgb, px_last},
              {exp_px[0].row, exp_px[0].col, exp_px[0].rgb, exp_px[0].last});
          if (px_ready) void'(exp_px.pop_front());
        end
      end
      if (on_valid) begin
        if (exp_on.size() == 0) chk("on unexpected report", {48'd0, on_cycles}, 64'hffff_ffff);
        else begin
          chk("on report", {on_row, on_cycles}, {exp_on[0].row, exp_on[0].cyc});
          void'(exp_on.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset outputs");
    rst = 1'b0;
    tick();
    // single lit pixel at column 0, with latch-to-valid latency pinned by hand
    shift(3'b100);
    for (int k = 1; k < 32; k++) shift(3'b000);
    row = 3'd0; lat = 1'b1; tick();
    chk("latch +1 valid", {63'd0, px_valid}, 64'd0);
    lat = 1'b0; tick();
    chk("latch +2 beat0", {px_valid, px_column, px_rgb}, {1'b1, 5'd0, 3'b100});
    wait_idle("row0");
    flags("row0", 3'b000);
    // on-time of 1024 cycles, report two cycles after the fall
    oe = 1'b1;
    repeat (1024) tick();
    oe = 1'b0; tick();
    chk("on +1 quiet", {63'd0, on_valid}, 64'd0);
    chk("on model 1024", {48'd0, exp_on[$].cyc}, 64'd1024);
    tick();
    chk("on +2 report", {on_valid, on_row, on_cycles}, {1'b1, 3'd0, 16'd1024});
    tick();
    // graded row
    for (int k = 0; k < 32; k++) shift(3'(k));
    latch(3'd5);
    wait_idle("row5");
    flags("row5", 3'b000);
    // short row: column 31 keeps the previous row's value
    for (int k = 0; k < 31; k++) shift(3'b011);
    latch(3'd1);
    watch_col("short col31 retained", 3'b111);
    wait_idle("short");
    flags("short", 3'b100);
    // long row: the 33rd shift is dropped
    for (int k = 0; k < 33; k++) shift(3'(k) ^ 3'b101);
    latch(3'd2);
    watch_col("long col31 is 32nd bit", 3'b010);
    wait_idle("long");
    // stall mid-row, overrun latch during the stall
    for (int k = 0; k < 32; k++) shift(3'(k * 3));
    latch(3'd3);
    repeat (5) tick();
    chk("stall start col", {59'd0, px_column}, 64'd5);
    px_ready = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 32; k++) shift(3'b001);
    latch(3'd7);
    repeat (5) tick();
    chk("stall held", {px_valid, px_row, px_column, px_rgb}, {1'b1, 3'd3, 5'd5, 3'b111});
    px_ready = 1'b1;
    wait_idle("stall");
    flags("overrun", 3'b101);
    // latch with LEDs lit, then a very long on-time
    oe = 1'b1;
    repeat (3) tick();
    latch(3'd4);
    repeat (70000) tick();
    oe = 1'b0; tick(); tick();
    chk("on saturate", {on_valid, on_row, on_cycles}, {1'b1, 3'd4, 16'hffff});
    tick();
    wait_idle("lit latch");
    flags("latch oe", 3'b111);
    // asynchronous reset mid-stream, then a clean row
    for (int k = 0; k < 32; k++) shift(3'b110);
    latch(3'd6);
    repeat (4) tick();
    chk("pre reset valid", {63'd0, px_valid}, 64'd1);
    #2 rst = 1'b1;
    #1 all_zero("mid-stream reset");
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 32; k++) shift(3'(k) ^ 3'b011);
    latch(3'd2);
    wait_idle("post reset");
    flags("post reset", 3'b000);
    repeat (4) tick();
    chk("queues drained", {32'(exp_px.size()), 32'(exp_on.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
